// File: rtl/seq_detect_prog.sv
// Runtime-programmable Mealy serial-bit sequence detector with an overlap mode,
// an input-valid qualifier, a registered match copy and a saturating match counter.
module seq_detect_prog #(
  parameter int unsigned          MAX_LEN = 8,
  parameter int unsigned          CNT_W   = 16,
  parameter logic [MAX_LEN-1:0]   RST_PAT = MAX_LEN'(9),
  parameter int unsigned          RST_LEN = 4,
  parameter bit                   RST_OVL = 1'b0,
  localparam int unsigned         LW      = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LW-1:0]      len_i,
  input  logic               ovl_i,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_cnt
);

  // The oldest window bit always comes from hist[MAX_LEN-2], so the top history bit is never kept.
  logic [MAX_LEN-2:0] hist, hist_nx;
  logic [MAX_LEN-1:0] pat, pat_nx, win, mask;
  logic [LW-1:0]      fill, fill_nx, len, len_nx;
  logic               ovl, ovl_nx;
  logic               accept, fill_ok, hit;
  logic [CNT_W-1:0]   cnt_nx;

  // Match decode and next-state for history, fill, configuration and counter.
  always_comb begin
    hist_nx = hist;
    fill_nx = fill;
    pat_nx  = pat;
    len_nx  = len;
    ovl_nx  = ovl;
    cnt_nx  = match_cnt;
    mask    = '0;

    win    = {hist, in};
    accept = in_valid & ~cfg_load;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = ((LW+1)'(i) < (LW+1)'(len));
    end
    fill_ok = ((LW+1)'(fill) + (LW+1)'(1)) >= (LW+1)'(len);
    hit     = ((win ^ pat) & mask) == '0;
    match   = accept & fill_ok & hit;

    if (cfg_load) begin
      pat_nx  = pat_i;
      ovl_nx  = ovl_i;
      fill_nx = '0;
      hist_nx = '0;
      if (len_i == '0) begin
        len_nx = LW'(1);
      end else if (len_i > LW'(MAX_LEN)) begin
        len_nx = LW'(MAX_LEN);
      end else begin
        len_nx = len_i;
      end
    end else if (in_valid) begin
      hist_nx = win[MAX_LEN-2:0];
      // Non-overlapping mode forgets everything once a match completes.
      if (match && !ovl) begin
        fill_nx = '0;
      end else if (fill != LW'(MAX_LEN)) begin
        fill_nx = fill + LW'(1);
      end
    end

    if (cnt_clr) begin
      cnt_nx = '0;
    end else if (match && (match_cnt != '1)) begin
      cnt_nx = match_cnt + CNT_W'(1);
    end
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= RST_PAT;
      len       <= LW'(RST_LEN);
      ovl       <= RST_OVL;
      match_q   <= 1'b0;
      match_cnt <= '0;
    end else begin
      hist      <= hist_nx;
      fill      <= fill_nx;
      pat       <= pat_nx;
      len       <= len_nx;
      ovl       <= ovl_nx;
      match_q   <= match;
      match_cnt <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: a behavioural model pushes expected outputs
// when each cycle is driven; a negedge monitor pops and compares them.
module tb_seq_detect_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LW      = 4;

  logic               clk = 1'b0;
  logic               rst, in_valid, in, cfg_load, ovl_i, cnt_clr;
  logic [MAX_LEN-1:0] pat_i;
  logic [LW-1:0]      len_i;
  logic               match, match_q, match2, match_q2;
  logic [15:0]        match_cnt;
  logic [1:0]         match_cnt2;

  seq_detect_prog u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .pat_i(pat_i), .len_i(len_i), .ovl_i(ovl_i), .cnt_clr(cnt_clr),
    .match(match), .match_q(match_q), .match_cnt(match_cnt)
  );

  seq_detect_prog #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .pat_i(pat_i), .len_i(len_i), .ovl_i(ovl_i), .cnt_clr(cnt_clr),
    .match(match2), .match_q(match_q2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        m;
    logic        mq;
    logic [15:0] c;
    logic [1:0]  c2;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural reference state.
  logic [7:0]  mh, mpat;
  int          mfill, mlen;
  logic        movl, mq;
  logic [15:0] mc;
  logic [1:0]  mc2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".match"},   32'(match),      32'(e.m));
      chk({e.tag, ".match2"},  32'(match2),     32'(e.m));
      chk({e.tag, ".match_q"}, 32'(match_q),    32'(e.mq));
      chk({e.tag, ".cnt"},     32'(match_cnt),  32'(e.c));
      chk({e.tag, ".cnt2"},    32'(match_cnt2), 32'(e.c2));
    end
  end

  task automatic model_reset();
    mh = '0; mfill = 0; mpat = 8'b0000_1001; mlen = 4; movl = 1'b0;
    mq = 1'b0; mc = '0; mc2 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, predict outputs, then advance the model past the edge.
  task automatic drive(input string tag, input logic v, input logic b,
                       input logic ld = 1'b0, input logic clr = 1'b0,
                       input logic [7:0] p = '0, input logic [3:0] l = '0,
                       input logic o = 1'b0);
    logic [7:0] w;
    logic       ok, m;
    exp_t       e;
    in_valid = v; in = b; cfg_load = ld; cnt_clr = clr;
    pat_i = p; len_i = l; ovl_i = o;
    w  = {mh[6:0], b};
    ok = 1'b1;
    for (int i = 0; i < mlen; i++) if (w[i] !== mpat[i]) ok = 1'b0;
    m = v && !ld && (mfill >= mlen - 1) && ok;
    e.tag = tag; e.m = m; e.mq = mq; e.c = mc; e.c2 = mc2;
    exp_q.push_back(e);
    @(posedge clk); #1;
    mq = m;
    if (clr) begin
      mc = '0; mc2 = '0;
    end else if (m) begin
      if (mc != 16'hFFFF) mc = mc + 16'd1;
      if (mc2 != 2'd3) mc2 = mc2 + 2'd1;
    end
    if (ld) begin
      mpat = p; movl = o; mfill = 0; mh = '0;
      mlen = (l == 0) ? 1 : (int'(l) > 8) ? 8 : int'(l);
    end else if (v) begin
      mh = {mh[6:0], b};
      if (m && !movl) mfill = 0;
      else if (mfill < 8) mfill++;
    end
    in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic send(input string tag, input logic [15:0] bits, input int n);
    logic [15:0] s;
    s = bits;
    for (int i = n - 1; i >= 0; i--) drive(tag, 1'b1, s[i]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    pat_i = '0; len_i = '0; ovl_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    drive("rst_idle", 1'b0, 1'b1);
    drive("rst_fill0", 1'b1, 1'b1);
    do_reset();

    // Default 1001, non-overlapping.
    send("t1", 16'b1001001, 7);
    chk("t1.cnt_final", 32'(match_cnt), 32'd1);

    // 1001 overlapping.
    drive("t2.load", 1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_1001, 4'd4, 1'b1);
    send("t2", 16'b1001001, 7);
    chk("t2.cnt_final", 32'(match_cnt), 32'd2);

    // Full-length pattern with a 3-cycle valid gap.
    begin
      logic [15:0] s;
      s = 16'b1011_0110_1011_0110;
      drive("t3.load", 1'b0, 1'b0, 1'b1, 1'b1, 8'b1011_0110, 4'd8, 1'b0);
      for (int i = 15; i >= 0; i--) begin
        if (i == 10) repeat (3) drive("t3.gap", 1'b0, 1'b1);
        drive("t3", 1'b1, s[i]);
      end
    end
    chk("t3.cnt_final", 32'(match_cnt), 32'd2);

    // Single-bit pattern and 2-bit counter saturation.
    drive("t4.load", 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0);
    send("t4", 16'b1101, 4);
    chk("t4.cnt2_3", 32'(match_cnt2), 32'd3);
    send("t4.sat", 16'b11, 2);
    chk("t4.cnt2_sat", 32'(match_cnt2), 32'd3);
    chk("t4.cnt_5", 32'(match_cnt), 32'd5);
    drive("t4.clr_hit", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t4.clr_wins", 32'(match_cnt), 32'd0);
    chk("t4.clr_wins2", 32'(match_cnt2), 32'd0);

    // Length clamps: 0 -> 1, 15 -> MAX_LEN.
    drive("t5.len0", 1'b0, 1'b0, 1'b1, 1'b0, 8'hF1, 4'd0, 1'b0);
    send("t5.l1", 16'b101, 3);
    drive("t5.len15", 1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_1010, 4'd15, 1'b0);
    send("t5.l8", 16'b1100_1010_1100_1010, 16);
    chk("t5.cnt_final", 32'(match_cnt), 32'd2);

    // Reset mid-pattern discards progress.
    do_reset();
    send("t6.pre", 16'b100, 3);
    do_reset();
    drive("t6.post", 1'b1, 1'b1);
    chk("t6.cnt", 32'(match_cnt), 32'd0);

    // cfg_load on the completing bit suppresses the match.
    send("t7.pre", 16'b100, 3);
    drive("t7.ld_hit", 1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_1001, 4'd4, 1'b0);
    chk("t7.cnt", 32'(match_cnt), 32'd0);
    drive("t7.tail", 1'b0, 1'b0);

    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
